// File: rtl/adc_pkg.sv
// Shared types and defaults for the ADC SPI reader: FSM state encoding,
// result width and the default clock divider / staleness timeout.
package adc_pkg;
  localparam int DATA_W             = 24;
  localparam int SCLK_DIV_DEF       = 50;
  localparam int TIMEOUT_CYCLES_DEF = 100000000;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    DONE
  } state_t;
endpackage

// File: rtl/adc_spi_reader_if.sv
// Bundle of the ADC-facing SPI pins and the conversion result outputs.
// The reader drives through the master modport; the ADC side and result consumer use slave.
interface adc_spi_reader_if;
  import adc_pkg::*;

  logic              adc_drdy_n;
  logic              adc_miso;
  logic              adc_sclk;
  logic              adc_cs_n;
  logic [DATA_W-1:0] adc_value;
  logic              adc_valid;
  logic              busy;
  logic              adc_stale;

  modport master (
    input  adc_drdy_n, adc_miso,
    output adc_sclk, adc_cs_n, adc_value, adc_valid, busy, adc_stale
  );

  modport slave (
    output adc_drdy_n, adc_miso,
    input  adc_sclk, adc_cs_n, adc_value, adc_valid, busy, adc_stale
  );
endinterface

// File: rtl/adc_spi_reader_sync2.sv
// Two-flop synchronizer for a single asynchronous input; the reset value is
// chosen per signal so an idle line does not look like activity after reset.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;
endmodule

// File: rtl/adc_spi_reader.sv
// Reads one 24-bit conversion over SPI after each DRDY falling edge, optionally
// clamps negative results to zero, and flags the reading as stale on timeout.
module adc_spi_reader
  import adc_pkg::*;
#(
  parameter int SCLK_DIV       = SCLK_DIV_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter bit CLAMP_NEG      = 1'b1
) (
  input logic              CLK100MHZ,
  input logic              rst,
  adc_spi_reader_if.master bus
);
  localparam int              TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [8:0]      HALF_LAST = 9'(SCLK_DIV - 1);
  localparam logic [8:0]      FULL_LAST = 9'(2 * SCLK_DIV - 1);
  localparam logic [4:0]      LAST_BIT  = 5'(DATA_W - 1);
  localparam logic [TW-1:0]   TMAX      = TW'(TIMEOUT_CYCLES);

  function automatic logic [DATA_W-1:0] clamp_result(input logic signed [DATA_W-1:0] raw);
    if (CLAMP_NEG && (raw < 0)) return '0;
    return $unsigned(raw);
  endfunction

  logic              drdy_s;
  logic              miso_s;
  logic              drdy_prev;
  logic [1:0]        settle;
  logic              drdy_fall;
  state_t            state;
  logic [8:0]        div_cnt;
  logic [4:0]        bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [TW-1:0]     tmo_cnt;
  logic              sclk;
  logic              cs_n;
  logic [DATA_W-1:0] value;
  logic              valid;
  logic              busy;

  sync2 #(.RST_VAL(1'b1)) u_sync_drdy (
    .clk (CLK100MHZ),
    .rst (rst),
    .d   (bus.adc_drdy_n),
    .q   (drdy_s)
  );

  sync2 #(.RST_VAL(1'b0)) u_sync_miso (
    .clk (CLK100MHZ),
    .rst (rst),
    .d   (bus.adc_miso),
    .q   (miso_s)
  );

  // Edge detection stays blind until the synchronizer has flushed its reset
  // value, so a DRDY already low during reset never reads as a fresh edge.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      drdy_prev <= 1'b1;
      settle    <= '0;
    end else begin
      drdy_prev <= drdy_s;
      if (settle != 2'd3) settle <= settle + 2'd1;
    end
  end

  assign drdy_fall = (settle == 2'd3) && drdy_prev && !drdy_s;

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state   <= IDLE;
      cs_n    <= 1'b1;
      sclk    <= 1'b0;
      value   <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          cs_n <= 1'b1;
          sclk <= 1'b0;
          if (drdy_fall) begin
            state   <= CS_SETUP;
            cs_n    <= 1'b0;
            busy    <= 1'b1;
            div_cnt <= '0;
          end
        end
        CS_SETUP: begin
          if (div_cnt == HALF_LAST) begin
            state   <= SHIFT;
            sclk    <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 9'd1;
          end
        end
        // Each bit: SCLK high for the first half-period, low for the second.
        SHIFT: begin
          if (div_cnt == HALF_LAST) sclk <= 1'b0;
          if (div_cnt == FULL_LAST) begin
            div_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              state <= CS_HOLD;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
              sclk    <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 9'd1;
          end
        end
        CS_HOLD: begin
          if (div_cnt == HALF_LAST) begin
            state <= DONE;
            cs_n  <= 1'b1;
            valid <= 1'b1;
            value <= clamp_result(shreg);
          end else begin
            div_cnt <= div_cnt + 9'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // MISO is captured on the SCLK high-to-low transition, MSB first.
  always_ff @(posedge CLK100MHZ) begin
    if (state == SHIFT && div_cnt == HALF_LAST) shreg <= {shreg[DATA_W-2:0], miso_s};
  end

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (valid) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMAX) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  assign bus.adc_sclk  = sclk;
  assign bus.adc_cs_n  = cs_n;
  assign bus.adc_value = value;
  assign bus.adc_valid = valid;
  assign bus.busy      = busy;
  assign bus.adc_stale = (tmo_cnt == TMAX);
endmodule

// File: tb/tb_adc_spi_reader.sv
// Directed bench for adc_spi_reader: SPI ADC models, an expected-value queue
// filled when a conversion is launched and drained when adc_valid pulses.
module tb_adc_spi_reader;
  import adc_pkg::*;

  localparam int DIV_A = SCLK_DIV_DEF;
  localparam int DIV_B = 4;
  localparam int TMO   = 5000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adc_spi_reader_if bus_a ();
  adc_spi_reader_if bus_b ();

  adc_spi_reader #(.SCLK_DIV(DIV_A), .TIMEOUT_CYCLES(TMO), .CLAMP_NEG(1'b1)) u_dut_a (
    .CLK100MHZ (clk),
    .rst       (rst),
    .bus       (bus_a)
  );

  adc_spi_reader #(.SCLK_DIV(DIV_B), .TIMEOUT_CYCLES(TMO), .CLAMP_NEG(1'b0)) u_dut_b (
    .CLK100MHZ (clk),
    .rst       (rst),
    .bus       (bus_b)
  );

  // ADC models: present the next bit on each SCLK rise, MSB first after CS falls.
  logic [23:0] word_a = '0;
  logic [23:0] word_b = '0;
  logic        miso_a = 1'b0;
  logic        miso_b = 1'b0;
  int          idx_a  = 23;
  int          idx_b  = 23;
  int          falls_a = 0;

  assign bus_a.adc_miso = miso_a;
  assign bus_b.adc_miso = miso_b;

  always @(negedge bus_a.adc_cs_n or posedge bus_a.adc_sclk) begin
    if (bus_a.adc_sclk) begin
      miso_a = word_a[idx_a];
      if (idx_a > 0) idx_a--;
    end else begin
      idx_a = 23;
    end
  end

  always @(negedge bus_b.adc_cs_n or posedge bus_b.adc_sclk) begin
    if (bus_b.adc_sclk) begin
      miso_b = word_b[idx_b];
      if (idx_b > 0) idx_b--;
    end else begin
      idx_b = 23;
    end
  end

  always @(negedge bus_a.adc_sclk) falls_a++;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_a(input logic [23:0] w);
    word_a = w;
    bus_a.adc_drdy_n = 1'b1;
    step(3);
    bus_a.adc_drdy_n = 1'b0;
  endtask

  task automatic wait_busy_a(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (bus_a.busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid_a(input int bound, output int t, output bit ok);
    ok = 1'b0;
    t  = 0;
    while (t < bound) begin
      step(1);
      t++;
      if (bus_a.adc_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Full transaction on DUT A; returns on the negedge where adc_valid is seen.
  task automatic run_a(input logic [23:0] w, input string tag);
    bit          ok;
    int          t;
    int          f0;
    logic [23:0] e;
    f0 = falls_a;
    start_a(w);
    wait_busy_a(ok);
    check({tag, "_start"}, 32'(ok), 32'd1);
    wait_valid_a(3000, t, ok);
    check({tag, "_valid"}, 32'(ok), 32'd1);
    if (ok) begin
      check({tag, "_latency"}, 32'(t), 32'(50 * DIV_A));
      e = exp_q.pop_front();
      check({tag, "_value"}, 32'(bus_a.adc_value), 32'(e));
      check({tag, "_sclk_falls"}, 32'(falls_a - f0), 32'd24);
    end
  endtask

  initial begin
    bit          ok;
    bit          saw;
    int          t;
    logic [23:0] e;

    bus_a.adc_drdy_n = 1'b0;
    bus_b.adc_drdy_n = 1'b1;
    rst = 1'b1;
    step(5);
    check("rst_cs_n",   32'(bus_a.adc_cs_n),  32'd1);
    check("rst_sclk",   32'(bus_a.adc_sclk),  32'd0);
    check("rst_value",  32'(bus_a.adc_value), 32'd0);
    check("rst_valid",  32'(bus_a.adc_valid), 32'd0);
    check("rst_busy",   32'(bus_a.busy),      32'd0);
    check("rst_stale",  32'(bus_a.adc_stale), 32'd0);
    check("rst_b_cs_n", 32'(bus_b.adc_cs_n),  32'd1);
    rst = 1'b0;

    // DRDY low through reset must not start anything; stale rises at 5000.
    saw = 1'b0;
    for (int i = 0; i < TMO - 1; i++) begin
      step(1);
      saw |= bus_a.busy | bus_a.adc_valid;
      if (i == 20) bus_a.adc_drdy_n = 1'b1;
    end
    check("drdy_low_in_rst", 32'(saw), 32'd0);
    check("stale_before", 32'(bus_a.adc_stale), 32'd0);
    step(1);
    check("stale_at_tmo", 32'(bus_a.adc_stale), 32'd1);

    exp_q.push_back(24'h5A5A5A);
    run_a(24'h5A5A5A, "basic");
    check("basic_cs_n_done", 32'(bus_a.adc_cs_n),  32'd1);
    check("basic_stale_hold", 32'(bus_a.adc_stale), 32'd1);
    step(1);
    check("basic_pulse_1cyc", 32'(bus_a.adc_valid), 32'd0);
    check("basic_stale_clr",  32'(bus_a.adc_stale), 32'd0);
    check("basic_idle_busy",  32'(bus_a.busy),      32'd0);
    check("basic_value_hold", 32'(bus_a.adc_value), 32'h5A5A5A);

    exp_q.push_back(24'h000000);
    run_a(24'h800001, "clamp_neg");

    // Second DRDY edge mid-transaction is dropped.
    exp_q.push_back(24'h123456);
    start_a(24'h123456);
    wait_busy_a(ok);
    check("ignore_start", 32'(ok), 32'd1);
    step(1000);
    bus_a.adc_drdy_n = 1'b1;
    step(3);
    bus_a.adc_drdy_n = 1'b0;
    wait_valid_a(3000, t, ok);
    check("ignore_valid", 32'(ok), 32'd1);
    e = exp_q.pop_front();
    check("ignore_value", 32'(bus_a.adc_value), 32'(e));
    saw = 1'b0;
    for (int i = 0; i < 2700; i++) begin
      step(1);
      saw |= bus_a.adc_valid | (i > 1 ? bus_a.busy : 1'b0);
    end
    check("ignore_no_queue", 32'(saw), 32'd0);

    exp_q.push_back(24'h2DC6C0);
    run_a(24'h2DC6C0, "b2b_first");
    step(1);
    check("b2b_gap_busy", 32'(bus_a.busy), 32'd0);
    exp_q.push_back(24'h3B8260);
    run_a(24'h3B8260, "b2b_second");

    // Reset in the middle of SHIFT aborts the transfer.
    start_a(24'hFFFFFF);
    wait_busy_a(ok);
    check("abort_start", 32'(ok), 32'd1);
    step(DIV_A + 1200);
    check("abort_in_shift", 32'(bus_a.adc_cs_n), 32'd0);
    rst = 1'b1;
    step(1);
    check("abort_cs_n",  32'(bus_a.adc_cs_n),  32'd1);
    check("abort_sclk",  32'(bus_a.adc_sclk),  32'd0);
    check("abort_busy",  32'(bus_a.busy),      32'd0);
    check("abort_valid", 32'(bus_a.adc_valid), 32'd0);
    check("abort_value", 32'(bus_a.adc_value), 32'd0);
    rst = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      step(1);
      saw |= bus_a.adc_valid | bus_a.busy;
    end
    check("abort_quiet", 32'(saw), 32'd0);
    check("abort_value_after", 32'(bus_a.adc_value), 32'd0);

    // Unclamped instance with a fast divider keeps the raw negative code.
    word_b = 24'h800001;
    exp_q.push_back(24'h800001);
    step(5);
    bus_b.adc_drdy_n = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (bus_b.busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("noclamp_start", 32'(ok), 32'd1);
    ok = 1'b0;
    t  = 0;
    while (t < 400) begin
      step(1);
      t++;
      if (bus_b.adc_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("noclamp_valid", 32'(ok), 32'd1);
    check("noclamp_latency", 32'(t), 32'(50 * DIV_B));
    e = exp_q.pop_front();
    check("noclamp_value", 32'(bus_b.adc_value), 32'(e));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_spi_reader.md
ADC_SPI_READER -- requirements
Module: adc_spi_reader

Interface
REQ-001 Parameter SCLK_DIV, default 50, system clocks per SCLK half-period (1 MHz SCLK at 100 MHz); legal range 4..255.
REQ-002 Parameter TIMEOUT_CYCLES, default 100000000, clocks without a completed conversion before adc_stale asserts.
REQ-003 Parameter CLAMP_NEG, default 1; when 1, a negative two's-complement result is reported as 24'd0.
REQ-004 CLK100MHZ  in  1  sole system clock; all logic on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 adc_drdy_n  in  1  ADC data-ready, active low, asynchronous to CLK100MHZ.
REQ-007 adc_miso  in  1  ADC serial data out, asynchronous to CLK100MHZ.
REQ-008 adc_sclk  out  1  SPI clock to ADC, idles low.
REQ-009 adc_cs_n  out  1  SPI chip select, active low.
REQ-010 adc_value  out  24  last completed conversion, held between updates; feeds the battery percentage display.
REQ-011 adc_valid  out  1  one-cycle pulse coincident with each adc_value update.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 adc_stale  out  1  high when no conversion has completed within TIMEOUT_CYCLES.

Function
REQ-014 adc_drdy_n and adc_miso SHALL each pass through a 2-flop synchronizer before use.
REQ-015 A transaction SHALL start only on a synchronized high-to-low transition of adc_drdy_n detected while in IDLE.
REQ-016 States: IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> DONE -> IDLE; no other transitions except reset.
REQ-017 CS_SETUP: adc_cs_n low, adc_sclk low, for exactly SCLK_DIV cycles.
REQ-018 SHIFT: 24 SCLK periods, each SCLK_DIV cycles high then SCLK_DIV cycles low (48*SCLK_DIV cycles total).
REQ-019 Synchronized adc_miso SHALL be sampled in the cycle adc_sclk goes high-to-low, shifted in MSB first; bit counter 0..23.
REQ-020 CS_HOLD: adc_sclk low, adc_cs_n low for SCLK_DIV cycles; adc_cs_n SHALL return high on entry to DONE.
REQ-021 DONE lasts one cycle: adc_value loads result, adc_valid = 1; IDLE follows next cycle.
REQ-022 Latency from detected DRDY edge to adc_valid: 50*SCLK_DIV + 1 cycles (2501 at default).
REQ-023 If CLAMP_NEG = 1 and shifted bit 23 = 1, adc_value SHALL load 24'd0; otherwise raw 24 bits.
REQ-024 DRDY falling edges occurring while busy SHALL be ignored and not queued.
REQ-025 adc_cs_n SHALL be high and adc_sclk low whenever state is IDLE.
REQ-026 Timeout counter SHALL clear on adc_valid, increment otherwise, saturate at TIMEOUT_CYCLES; adc_stale = counter == TIMEOUT_CYCLES.
REQ-027 adc_stale SHALL deassert in the cycle after adc_valid.

Reset
REQ-028 On rst: state IDLE, adc_cs_n = 1, adc_sclk = 0, adc_value = 0, adc_valid = 0, busy = 0, adc_stale = 0, counters and synchronizers cleared (synchronizer flops reset to 1 for adc_drdy_n).
REQ-029 rst mid-transaction SHALL abort it: no adc_valid, adc_value stays 0, cs_n high on the following cycle.
REQ-030 A DRDY edge present during rst SHALL not start a transaction after release; only edges detected after rst deasserts count.

Structure
REQ-031 Shared package adc_pkg SHALL hold the state enum and the SCLK_DIV / TIMEOUT_CYCLES defaults.
REQ-032 One sub-module, sync2 (2-flop synchronizer), instantiated twice.

Verification
REQ-033 ADC model returns 24'h5A5A5A after DRDY falling edge -> adc_valid pulse 2501 cycles after detected edge, adc_value = 24'h5A5A5A, exactly 24 SCLK falling edges.
REQ-034 Model returns 24'h800001, CLAMP_NEG = 1 -> adc_value = 0; with CLAMP_NEG = 0 -> 24'h800001.
REQ-035 Second DRDY falling edge 1000 cycles into a transaction -> ignored, single adc_valid, next transaction only on a later edge.
REQ-036 rst asserted 1200 cycles into SHIFT -> cs_n high next cycle, sclk low, no adc_valid, adc_value = 0.
REQ-037 TIMEOUT_CYCLES = 5000, no DRDY -> adc_stale high at cycle 5000 after reset; clears the cycle after next adc_valid.
REQ-038 Back-to-back conversions 24'h2DC6C0 then 24'h3B8260 -> adc_value updates in order, busy low one or more cycles between.
